arb_vrp_matrix_lock: RTL and testbench
======================================

Name: arb_vrp_matrix_lock

Overview:
- Packet-aware matrix arbiter that owns the priority matrix internally and shares one valid/ready/payload master port between WIDTH requesters.
- Grants one requester per packet, holds the grant (lock) until that requester's last beat completes, then demotes the winner to lowest priority (least-recently-granted).
- Sits upstream of a shared link, bus or FIFO, where multi-beat transfers must not interleave.

Parameters:
- WIDTH, 4, number of requesters (≥2).
- PLD_WIDTH, 32, payload bits per beat.
- TIMEOUT, 16, idle cycles tolerated inside a lock before forced release (used only with the optional feature; ≥2).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- v_vld_s  input  WIDTH  per-requester beat valid.
- v_rdy_s  output  WIDTH  per-requester beat ready, at most one bit set.
- v_pld_s  input  PLD_WIDTH x WIDTH (unpacked array)  per-requester payload.
- v_last_s  input  WIDTH  per-requester last beat of packet.
- vld_m  output  1  master beat valid.
- rdy_m  input  1  master ready.
- pld_m  output  PLD_WIDTH  selected payload.
- last_m  output  1  selected last flag.
- locked  output  1  arbiter is in LOCK state.
- gnt_idx  output  $clog2(WIDTH)  index currently granted or locked; valid when vld_m=1.
- err_timeout  output  1  one-cycle pulse on forced lock release (optional feature).

Behaviour:
- Matrix: WIDTH x WIDTH register, m[i][j]=1 means i beats j; diagonal unused, constant 0. Invariant: m[i][j] = ~m[j][i] for i≠j.
- Reset: m[i][j]=1 for j>i (index 0 highest priority); state ARB; lock index 0; timeout counter 0.
- Outputs during and after reset (combinational, from the reset state): locked=0, err_timeout=0; v_rdy_s, vld_m, pld_m and last_m follow the ARB equations on current inputs.
- ARB grant: g[i] = v_vld_s[i] & AND over j≠i of (~v_vld_s[j] | m[i][j]). This is exactly one-hot when any request is valid.
- ARB outputs:
  - vld_m = |v_vld_s.
  - pld_m and last_m come from the granted index (zero when none).
  - v_rdy_s = g & {WIDTH{rdy_m}}.
  - gnt_idx = encode(g).
- No combinational path from rdy_m to vld_m.
- Handshake: a beat transfers when vld_m & rdy_m.
- ARB → LOCK: on a transfer with last_m=0; lock index := granted index. The matrix is not updated.
- ARB, transfer with last_m=1 (single-beat packet): stay in ARB; update the matrix the same edge.
- LOCK outputs, with L = lock index:
  - vld_m = v_vld_s[L].
  - pld_m and last_m come from L.
  - v_rdy_s = onehot(L) & {WIDTH{rdy_m}}; other requesters see rdy=0 regardless of priority.
- LOCK → ARB: on a transfer with last_m=1; update the matrix the same edge.
- Matrix update for winner w: m[w][j] := 0 and m[j][w] := 1 for all j≠w. All other entries are held.
- Latency: zero cycles, valid to master combinationally. The new priority takes effect on the cycle after the last beat.
- Back-pressure: with rdy_m=0 in either state, the grant and lock are held. The grant in ARB may change while no handshake occurs; the requester must hold vld/pld stable per protocol.
- Reset mid-packet: return to ARB immediately with the reset matrix. The partial packet is abandoned; the bench must not check its tail.

Optional Feature:
- Macro: ARB_VRP_LOCK_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCK cycle with v_vld_s[L]=0 and clears on any cycle with v_vld_s[L]=1.
  - When the counter reaches TIMEOUT-1 in LOCK, the next edge forces ARB, applies the matrix update for L, pulses err_timeout for one cycle, and clears the counter.
  - The counter is held at 0 in ARB.
- Undefined: no counter is instantiated, err_timeout is tied 0, and LOCK exits only on a last beat.

Test Plan:
- Reset, WIDTH=4, v_vld_s=4'b1111, all last=1, rdy_m=1 for 4 cycles -> grants to indices 0,1,2,3 in order; then 0 again.
- v_vld_s=4'b0110, last=1, rdy_m=1 -> grant index 1, then 2, then 1; v_rdy_s never has 2 bits set.
- Requester 2 sends a 3-beat packet (last on beat 3) while v_vld_s=4'b1111 -> locked=1 for beats 2–3, v_rdy_s=4'b0100 only, pld_m from index 2; next grant is index 0 and index 2 becomes lowest priority.
- In LOCK on index 1, hold rdy_m=0 for 5 cycles, then 1 -> vld_m stays 1, gnt_idx=1 throughout, beats are neither lost nor duplicated.
- Reset asserted during beat 2 of a 4-beat packet from index 3 -> next cycle locked=0 and the matrix is restored (index 0 wins with all valid).
- With ARB_VRP_LOCK_TIMEOUT_EN and TIMEOUT=16: lock index 1, then drop v_vld_s[1] for 16 cycles -> err_timeout pulses on cycle 16, locked=0 and the next grant goes to a different valid requester. Without the macro, locked stays 1 and err_timeout stays 0.

Source files
------------

// File: rtl/arb_vrp_matrix_lock.sv
// Packet-locking matrix arbiter (least-recently-granted) feeding one valid/ready master port.
// Optional lock-idle timeout is compiled in when ARB_VRP_LOCK_TIMEOUT_EN is defined.
module arb_vrp_matrix_lock #(
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         v_vld_s,
    output logic [WIDTH-1:0]         v_rdy_s,
    input  logic [PLD_WIDTH-1:0]     v_pld_s [WIDTH],
    input  logic [WIDTH-1:0]         v_last_s,
    output logic                     vld_m,
    input  logic                     rdy_m,
    output logic [PLD_WIDTH-1:0]     pld_m,
    output logic                     last_m,
    output logic                     locked,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic                     err_timeout
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {ARB, LOCK} state_t;

    state_t                      state, state_nxt;
    logic [WIDTH-1:0][WIDTH-1:0] m;
    logic [WIDTH-1:0]            g;
    logic [IW-1:0]               arb_idx, lock_idx, lock_idx_nxt, sel_idx, upd_idx;
    logic                        xfer, upd, force_rel;

    if (WIDTH < 2 || TIMEOUT < 2) begin : g_param_chk
        $error("arb_vrp_matrix_lock: WIDTH and TIMEOUT must both be >= 2");
    end

    // i wins when every other valid requester is beaten by i in the matrix
    always_comb begin
        g = v_vld_s;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                if (j != i) g[i] = g[i] & (~v_vld_s[j] | m[i][j]);
        arb_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (g[i]) arb_idx = arb_idx | IW'(i);
    end

    always_comb begin
        sel_idx = (state == LOCK) ? lock_idx : arb_idx;
        vld_m   = (state == LOCK) ? v_vld_s[lock_idx] : |v_vld_s;
        pld_m   = '0;
        last_m  = 1'b0;
        if (vld_m || state == LOCK) begin
            pld_m  = v_pld_s[sel_idx];
            last_m = v_last_s[sel_idx];
        end
        v_rdy_s = g & {WIDTH{rdy_m}};
        if (state == LOCK) begin
            v_rdy_s           = '0;
            v_rdy_s[lock_idx] = rdy_m;
        end
        gnt_idx = sel_idx;
        locked  = (state == LOCK);
    end

    assign xfer = vld_m & rdy_m;

    always_comb begin
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        upd          = 1'b0;
        upd_idx      = sel_idx;
        if (state == ARB) begin
            if (xfer && last_m) begin
                upd = 1'b1;
            end else if (xfer) begin
                state_nxt    = LOCK;
                lock_idx_nxt = arb_idx;
            end
        end else if ((xfer && last_m) || force_rel) begin
            state_nxt = ARB;
            upd       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // winner drops below everyone; diagonal stays at its reset value of 0
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                if (rst) begin
                    m[i][j] <= (j > i);
                end else if (upd && i != j) begin
                    if (upd_idx == IW'(i))      m[i][j] <= 1'b0;
                    else if (upd_idx == IW'(j)) m[i][j] <= 1'b1;
                end
    end

`ifdef ARB_VRP_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] to_cnt;

    assign force_rel = (state == LOCK) && !v_vld_s[lock_idx] && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= force_rel;
            if (state != LOCK || v_vld_s[lock_idx] || force_rel) to_cnt <= '0;
            else                                                 to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign force_rel   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb_vrp_matrix_lock.sv
// Scoreboard bench for arb_vrp_matrix_lock: expected beats queued as stimulus is set up, popped on each master transfer.
module tb_arb_vrp_matrix_lock;
    localparam int WIDTH     = 4;
    localparam int PLD_WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     v_vld_s, v_rdy_s, v_last_s;
    logic [PLD_WIDTH-1:0] v_pld_s [WIDTH];
    logic                 vld_m, rdy_m, last_m, locked, err_timeout;
    logic [PLD_WIDTH-1:0] pld_m;
    logic [1:0]           gnt_idx;

    arb_vrp_matrix_lock #(.WIDTH(WIDTH), .PLD_WIDTH(PLD_WIDTH), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst),
        .v_vld_s(v_vld_s), .v_rdy_s(v_rdy_s), .v_pld_s(v_pld_s), .v_last_s(v_last_s),
        .vld_m(vld_m), .rdy_m(rdy_m), .pld_m(pld_m), .last_m(last_m),
        .locked(locked), .gnt_idx(gnt_idx), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] pld;
        logic        last;
        logic        lck;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               failures = 0;
    int               len  [WIDTH];
    int               beat [WIDTH];
    int               pkt  [WIDTH];
    logic [WIDTH-1:0] en;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pld_of(input int i, input int p, input int b);
        return {8'(i), 8'(p), 16'(b)};
    endfunction

    task automatic drive();
        for (int i = 0; i < WIDTH; i++) begin
            v_vld_s[i]  = en[i];
            v_pld_s[i]  = pld_of(i, pkt[i], beat[i]);
            v_last_s[i] = (beat[i] == len[i] - 1);
        end
    endtask

    task automatic push(input int i, input int p, input int b, input logic lck);
        exp_t e;
        e.idx  = i;
        e.pld  = pld_of(i, p, b);
        e.last = (b == len[i] - 1);
        e.lck  = lck;
        sb.push_back(e);
    endtask

    task automatic clear_streams();
        for (int i = 0; i < WIDTH; i++) begin
            len[i]  = 1;
            beat[i] = 0;
            pkt[i]  = 0;
        end
    endtask

    // one cycle: sample at negedge, score any transfer, advance the streams after the edge
    task automatic tick();
        logic [WIDTH-1:0] acc;
        exp_t             e;
        @(negedge clk);
        acc = rst ? '0 : (v_vld_s & v_rdy_s);
        chk("rdy_onehot", ($countones(v_rdy_s) <= 1), 1);
        if (vld_m && rdy_m && !rst) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat_sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("gnt_idx", gnt_idx, e.idx);
                chk("pld_m", pld_m, e.pld);
                chk("last_m", last_m, e.last);
                chk("locked", locked, e.lck);
                chk("v_rdy_s", v_rdy_s, 4'b0001 << e.idx);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < WIDTH; i++)
            if (acc[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]++;
                end else begin
                    beat[i]++;
                end
            end
        drive();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rdy_m = 1'b1;
        en    = '0;
        sb.delete();
        clear_streams();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int errs;
        rst = 1'b1;
        rdy_m = 1'b1;
        en = '0;
        clear_streams();
        drive();

        // reset state and round-robin with all requesters valid
        do_reset();
        @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_vld_idle", vld_m, 0);
        @(posedge clk);
        #1;
        en = 4'b1111;
        drive();
        push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 0, 0, 0); push(0, 1, 0, 0);
        run(20);
        en = '0;
        drive();

        // two requesters alternate
        do_reset();
        en = 4'b0110;
        drive();
        push(1, 0, 0, 0); push(2, 0, 0, 0); push(1, 1, 0, 0);
        run(20);

        // 3-beat packet from requester 2 locks out higher-priority requesters
        do_reset();
        len[2] = 3;
        en = 4'b0100;
        drive();
        push(2, 0, 0, 0);
        run(10);
        en = 4'b1111;
        drive();
        push(2, 0, 1, 1); push(2, 0, 2, 1);
        push(0, 0, 0, 0); push(1, 0, 0, 0); push(3, 0, 0, 0); push(2, 1, 0, 0);
        run(30);

        // back-pressure inside a lock on requester 1
        do_reset();
        len[1] = 3;
        en = 4'b0010;
        drive();
        push(1, 0, 0, 0);
        run(10);
        en = 4'b0011;
        rdy_m = 1'b0;
        drive();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_vld", vld_m, 1);
            chk("stall_idx", gnt_idx, 1);
            chk("stall_locked", locked, 1);
            chk("stall_rdy", v_rdy_s, 0);
            @(posedge clk);
            #1;
        end
        rdy_m = 1'b1;
        push(1, 0, 1, 1); push(1, 0, 2, 1); push(0, 0, 0, 0);
        run(20);

        // reset mid-packet from requester 3 restores the reset matrix
        do_reset();
        len[3] = 4;
        en = 4'b1000;
        drive();
        push(3, 0, 0, 0);
        run(10);
        @(negedge clk);
        chk("mid_pkt_locked", locked, 1);
        rst = 1'b1;
        rdy_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_streams();
        len[3] = 4;
        en = 4'b1111;
        drive();
        @(negedge clk);
        chk("post_rst_locked", locked, 0);
        chk("post_rst_idx", gnt_idx, 0);
        chk("post_rst_vld", vld_m, 1);
        @(posedge clk);
        #1;
        rdy_m = 1'b1;
        push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0);
        run(20);

        // lock on requester 1, then it goes idle mid-packet
        do_reset();
        len[1] = 4;
        en = 4'b0010;
        drive();
        push(1, 0, 0, 0);
        run(10);
        en = 4'b0101;
        rdy_m = 1'b0;
        drive();
        errs = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (err_timeout) errs++;
            if (c == 15) chk("idle_lock_held", locked, 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
`ifdef ARB_VRP_LOCK_TIMEOUT_EN
        chk("timeout_pulses", errs, 1);
        chk("timeout_unlocked", locked, 0);
        chk("timeout_next_idx", gnt_idx, 0);
        chk("timeout_next_vld", vld_m, 1);
        @(posedge clk);
        #1;
        rdy_m = 1'b1;
        push(0, 0, 0, 0); push(2, 0, 0, 0);
        run(20);
`else
        chk("no_timeout_pulses", errs, 0);
        chk("no_timeout_locked", locked, 1);
        chk("no_timeout_idx", gnt_idx, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
